// File: rtl/ps2_pkg.sv
// ps2_pkg
//   Shared definitions for the PS/2 scan-code receiver: the deframing FSM
//   state type, frame geometry and the scan-code constants that the prefix
//   decoder recognises.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam int FRAME_DATA_BITS = 8;

    localparam logic [7:0] PS2_CODE_BREAK = 8'hF0;
    localparam logic [7:0] PS2_CODE_EXT   = 8'hE0;
    localparam logic [7:0] PS2_CODE_SPACE = 8'h29;

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter
//   Conditions the raw PS/2 lines for the receiver: a 2-FF synchroniser on
//   each line, a glitch filter on the clock line and a falling-edge strobe.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   ps2Clk_i   raw PS/2 clock line (asynchronous)
//   ps2Dat_i   raw PS/2 data line (asynchronous)
//   data_s_o   synchronised data line
//   fall_o     one-cycle strobe after the filtered clock falls; data_s_o is
//              meant to be sampled in that cycle
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2Clk_i,
    input  logic ps2Dat_i,
    output logic data_s_o,
    output logic fall_o
);

    localparam int CNT_W = $clog2(FILTER_LEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [1:0]       clkSync_q;
    logic [1:0]       datSync_q;
    logic             clkFilt_q;
    logic             clkFiltPrev_q;
    logic [CNT_W-1:0] stableCnt_q;

    // Both lines idle high, so the synchronisers and the filtered clock
    // reset to 1 to avoid a spurious fall strobe right after reset.
    // The filtered clock only follows the synchronised clock once it has
    // disagreed for FILTER_LEN consecutive samples; any sample that agrees
    // again restarts the count, which swallows short glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            clkSync_q     <= 2'b11;
            datSync_q     <= 2'b11;
            clkFilt_q     <= 1'b1;
            clkFiltPrev_q <= 1'b1;
            stableCnt_q   <= '0;
        end else begin
            clkSync_q     <= {clkSync_q[0], ps2Clk_i};
            datSync_q     <= {datSync_q[0], ps2Dat_i};
            clkFiltPrev_q <= clkFilt_q;
            if (clkSync_q[1] == clkFilt_q) begin
                stableCnt_q <= '0;
            end else if (stableCnt_q == CNT_LAST) begin
                clkFilt_q   <= clkSync_q[1];
                stableCnt_q <= '0;
            end else begin
                stableCnt_q <= stableCnt_q + 1'b1;
            end
        end
    end

    assign data_s_o = datSync_q[1];
    assign fall_o   = clkFiltPrev_q & ~clkFilt_q;

endmodule

// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver
//   PS/2 device-to-host receiver. Deframes 11-bit PS/2 frames (start, 8 data
//   bits LSB first, odd parity, stop), buffers good bytes in a small
//   first-word-fall-through FIFO and presents them through a
//   scan_code / scan_ready / read handshake.
//
//   Build option PS2_PREFIX_DECODE_EN: when defined, E0/F0 prefix bytes are
//   folded into ext/break flags stored alongside the following byte instead
//   of being buffered themselves.
//
// Ports
//   clk         50 MHz system clock
//   reset       synchronous, active-high reset
//   PS2_CLK     raw PS/2 clock line (asynchronous)
//   PS2_DAT     raw PS/2 data line (asynchronous)
//   read        single-cycle pop request
//   scan_code   FIFO head byte, valid while scan_ready
//   scan_ready  FIFO head valid
//   scan_break  head byte was preceded by F0 (prefix decode only, else 0)
//   scan_ext    head byte was preceded by E0 (prefix decode only, else 0)
//   frame_err   one-cycle pulse on parity, stop-bit or timeout error
//   overflow    sticky: a good byte was dropped because the FIFO was full
module ps2_scan_receiver
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    input  logic       read,
    output logic [7:0] scan_code,
    output logic       scan_ready,
    output logic       scan_break,
    output logic       scan_ext,
    output logic       frame_err,
    output logic       overflow
);

`ifdef PS2_PREFIX_DECODE_EN
    localparam int ENTRY_W = FRAME_DATA_BITS + 2;
`else
    localparam int ENTRY_W = FRAME_DATA_BITS;
`endif

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int BIT_W   = $clog2(FRAME_DATA_BITS);
    localparam int TMR_W   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] FIFO_FULL    = CNT_W'(FIFO_DEPTH);
    localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(FRAME_DATA_BITS - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic dataS;
    logic fall;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_filter (
        .clk      (clk),
        .reset    (reset),
        .ps2Clk_i (PS2_CLK),
        .ps2Dat_i (PS2_DAT),
        .data_s_o (dataS),
        .fall_o   (fall)
    );

    ps2_state_e                 state_q,    state_d;
    logic [BIT_W-1:0]           bitCnt_q,   bitCnt_d;
    logic [FRAME_DATA_BITS-1:0] shift_q,    shift_d;
    logic                       parityOk_q, parityOk_d;
    logic [TMR_W-1:0]           timer_q,    timer_d;
    logic                       frameErr_q, frameErr_d;
    logic                       frameGood;
    logic                       pushValid_q, pushValid_d;
    logic [ENTRY_W-1:0]         pushEntry_q, pushEntry_d;

    // Deframing FSM. It only moves on a fall strobe, except for the timeout
    // abort, which wins so a stalled frame can never linger past the limit.
    always_comb begin
        state_d    = state_q;
        bitCnt_d   = bitCnt_q;
        shift_d    = shift_q;
        parityOk_d = parityOk_q;
        frameErr_d = 1'b0;
        frameGood  = 1'b0;

        if (state_q == IDLE || fall) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end

        if (state_q != IDLE && timer_q == TIMEOUT_LAST) begin
            state_d    = IDLE;
            frameErr_d = 1'b1;
            timer_d    = '0;
        end else if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!dataS) begin
                        state_d  = DATA;
                        bitCnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d  = {dataS, shift_q[FRAME_DATA_BITS-1:1]};
                    bitCnt_d = bitCnt_q + 1'b1;
                    if (bitCnt_q == BIT_LAST) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parityOk_d = ^{shift_q, dataS};
                    state_d    = STOP;
                end
                STOP: begin
                    if (dataS && parityOk_q) begin
                        frameGood = 1'b1;
                    end else begin
                        frameErr_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef PS2_PREFIX_DECODE_EN
    logic pendBrk_q, pendBrk_d;
    logic pendExt_q, pendExt_d;

    // Prefix bytes only arm the pending flags; the next ordinary byte carries
    // them into the FIFO. Any framing error forgets a half-received sequence.
    always_comb begin
        pushValid_d = 1'b0;
        pushEntry_d = pushEntry_q;
        pendBrk_d   = pendBrk_q;
        pendExt_d   = pendExt_q;
        if (frameErr_d) begin
            pendBrk_d = 1'b0;
            pendExt_d = 1'b0;
        end else if (frameGood) begin
            if (shift_q == PS2_CODE_EXT) begin
                pendExt_d = 1'b1;
            end else if (shift_q == PS2_CODE_BREAK) begin
                pendBrk_d = 1'b1;
            end else begin
                pushValid_d = 1'b1;
                pushEntry_d = {pendBrk_q, pendExt_q, shift_q};
                pendBrk_d   = 1'b0;
                pendExt_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pendBrk_q <= 1'b0;
            pendExt_q <= 1'b0;
        end else begin
            pendBrk_q <= pendBrk_d;
            pendExt_q <= pendExt_d;
        end
    end
`else
    always_comb begin
        pushValid_d = frameGood;
        pushEntry_d = frameGood ? shift_q : pushEntry_q;
    end
`endif

    // The push and the error pulse are registered, so the FIFO write lands
    // one edge after the stop-bit fall cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            parityOk_q  <= 1'b0;
            timer_q     <= '0;
            frameErr_q  <= 1'b0;
            pushValid_q <= 1'b0;
            pushEntry_q <= '0;
        end else begin
            state_q     <= state_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            parityOk_q  <= parityOk_d;
            timer_q     <= timer_d;
            frameErr_q  <= frameErr_d;
            pushValid_q <= pushValid_d;
            pushEntry_q <= pushEntry_d;
        end
    end

    logic [ENTRY_W-1:0] fifoMem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wrPtr_q;
    logic [PTR_W-1:0]   rdPtr_q;
    logic [CNT_W-1:0]   count_q;
    logic               holdOff_q;
    logic               overflow_q;
    logic               notEmpty;
    logic               doPop;
    logic               doPush;
    logic [ENTRY_W-1:0] head;

    assign notEmpty   = (count_q != '0);
    assign scan_ready = notEmpty && !holdOff_q;
    assign doPop      = read && scan_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign doPush     = pushValid_q && (count_q != FIFO_FULL || doPop);
    assign head       = fifoMem_q[rdPtr_q];

    always_ff @(posedge clk) begin
        if (doPush) begin
            fifoMem_q[wrPtr_q] <= pushEntry_q;
        end
    end

    // holdOff_q drops scan_ready for one cycle after every pop so the
    // downstream edge-triggered oneshot sees a fresh rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            holdOff_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            holdOff_q <= doPop;
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            if (doPush && !doPop) begin
                count_q <= count_q + 1'b1;
            end else if (doPop && !doPush) begin
                count_q <= count_q - 1'b1;
            end
            if (pushValid_q && !doPush) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign scan_code = notEmpty ? head[FRAME_DATA_BITS-1:0] : 8'h00;
    assign frame_err = frameErr_q;
    assign overflow  = overflow_q;

`ifdef PS2_PREFIX_DECODE_EN
    assign scan_break = notEmpty && head[FRAME_DATA_BITS+1];
    assign scan_ext   = notEmpty && head[FRAME_DATA_BITS];
`else
    assign scan_break = 1'b0;
    assign scan_ext   = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// tb_ps2_scan_receiver
//   Scoreboard bench for ps2_scan_receiver. The stimulus process bit-bangs
//   PS/2 frames and queues the byte it expects to come out; a monitor
//   process compares each new FIFO head against the queue and pops it.
//   Honours PS2_PREFIX_DECODE_EN for the prefix expectations.
module tb_ps2_scan_receiver;

    localparam int FIFO_DEPTH     = 4;
    localparam int FILTER_LEN     = 4;
    localparam int TIMEOUT_CYCLES = 2000;
    localparam int HALF           = 12;

    logic       clk = 1'b0;
    logic       reset;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic       read;
    logic [7:0] scan_code;
    logic       scan_ready;
    logic       scan_break;
    logic       scan_ext;
    logic       frame_err;
    logic       overflow;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } expEntry_t;

    expEntry_t expQ[$];
    int        testsRun    = 0;
    int        testsFailed = 0;
    int        errPulses   = 0;
    bit        autoRead    = 1'b0;

    ps2_scan_receiver #(
        .FIFO_DEPTH     (FIFO_DEPTH),
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .PS2_CLK    (PS2_CLK),
        .PS2_DAT    (PS2_DAT),
        .read       (read),
        .scan_code  (scan_code),
        .scan_ready (scan_ready),
        .scan_break (scan_break),
        .scan_ext   (scan_ext),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #10 clk = ~clk;

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pushExp(input logic [7:0] code, input logic brk, input logic ext);
        expQ.push_back({code, brk, ext});
    endtask

    // Sends the first nBits of a frame (11 = whole frame). Data changes while
    // the line clock is high; glitchBit injects a 2-cycle low pulse on
    // PS2_CLK during that bit's high phase.
    task automatic applyStimulus(input logic [7:0] code, input bit badParity,
                                 input int glitchBit, input int nBits);
        logic [10:0] frame;
        frame = {1'b1, (~^code) ^ badParity, code, 1'b0};
        for (int i = 0; i < nBits; i++) begin
            PS2_DAT = frame[i];
            if (i == glitchBit) begin
                waitCycles(4);
                PS2_CLK = 1'b0;
                waitCycles(2);
                PS2_CLK = 1'b1;
                waitCycles(HALF - 6);
            end else begin
                waitCycles(HALF);
            end
            PS2_CLK = 1'b0;
            waitCycles(HALF);
            PS2_CLK = 1'b1;
        end
        PS2_DAT = 1'b1;
        waitCycles(4 * HALF);
    endtask

    // Waits (bounded) for the monitor to consume every queued byte.
    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while ((expQ.size() != 0 || scan_ready) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        waitCycles(2);
        checkOutput({name, " drained"}, expQ.size(), 0);
    endtask

    // Monitor: checks each new head once, pops it when autoRead is set and
    // verifies scan_ready drops for the cycle after every pop.
    initial begin : monitor
        bit        headChecked;
        bit        readIssued;
        expEntry_t e;
        headChecked = 1'b0;
        readIssued  = 1'b0;
        read        = 1'b0;
        forever begin
            @(negedge clk);
            read = 1'b0;
            if (reset) begin
                headChecked = 1'b0;
                readIssued  = 1'b0;
            end else begin
                if (readIssued) begin
                    checkOutput("ready gap after pop", scan_ready, 0);
                    readIssued = 1'b0;
                end
                if (scan_ready && !headChecked) begin
                    if (expQ.size() == 0) begin
                        testsRun++;
                        testsFailed++;
                        $display("[TB] FAIL unexpected byte: got 0x%0h, expected none", scan_code);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("scan_code", scan_code, e.code);
                        checkOutput("scan_break", scan_break, e.brk);
                        checkOutput("scan_ext", scan_ext, e.ext);
                    end
                    headChecked = 1'b1;
                end
                if (scan_ready && autoRead) begin
                    read        = 1'b1;
                    readIssued  = 1'b1;
                    headChecked = 1'b0;
                end
            end
        end
    end

    initial begin : errCounter
        forever begin
            @(negedge clk);
            if (!reset && frame_err) errPulses++;
        end
    end

    initial begin : watchdog
        #(20 * 150000);
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int e0;
        reset   = 1'b1;
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        waitCycles(5);
        checkOutput("reset scan_ready", scan_ready, 0);
        checkOutput("reset scan_code", scan_code, 0);
        checkOutput("reset scan_break", scan_break, 0);
        checkOutput("reset scan_ext", scan_ext, 0);
        checkOutput("reset frame_err", frame_err, 0);
        checkOutput("reset overflow", overflow, 0);
        reset = 1'b0;
        waitCycles(5);
        autoRead = 1'b1;

        // Clean 0x29 frame.
        e0 = errPulses;
        pushExp(8'h29, 1'b0, 1'b0);
        applyStimulus(8'h29, 1'b0, -1, 11);
        waitDrain("frame 29");
        checkOutput("no frame_err on good frame", errPulses - e0, 0);

        // Bad parity, then a clean 0x0F.
        e0 = errPulses;
        applyStimulus(8'h29, 1'b1, -1, 11);
        waitCycles(5);
        checkOutput("parity error pulse count", errPulses - e0, 1);
        checkOutput("ready after bad parity", scan_ready, 0);
        pushExp(8'h0F, 1'b0, 1'b0);
        applyStimulus(8'h0F, 1'b0, -1, 11);
        waitDrain("frame 0F");

        // Start bit plus 3 data bits, then the line stalls.
        e0 = errPulses;
        applyStimulus(8'h29, 1'b0, -1, 4);
        waitCycles(TIMEOUT_CYCLES + 100);
        checkOutput("timeout error pulse count", errPulses - e0, 1);
        checkOutput("ready after timeout", scan_ready, 0);
        pushExp(8'h29, 1'b0, 1'b0);
        applyStimulus(8'h29, 1'b0, -1, 11);
        waitDrain("frame 29 after timeout");
        checkOutput("no extra error after timeout", errPulses - e0, 1);

        // Five frames with nobody reading: the fifth is dropped.
        autoRead = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= FIFO_DEPTH) pushExp(8'(i), 1'b0, 1'b0);
            applyStimulus(8'(i), 1'b0, -1, 11);
        end
        checkOutput("overflow set", overflow, 1);
        checkOutput("ready while full", scan_ready, 1);
        autoRead = 1'b1;
        waitDrain("overflow burst");
        checkOutput("ready after draining", scan_ready, 0);
        checkOutput("overflow sticky", overflow, 1);

        // Short clock glitches in IDLE (data low) and mid-frame.
        e0 = errPulses;
        PS2_DAT = 1'b0;
        waitCycles(3);
        PS2_CLK = 1'b0;
        waitCycles(2);
        PS2_CLK = 1'b1;
        waitCycles(3);
        PS2_DAT = 1'b1;
        waitCycles(20);
        pushExp(8'h29, 1'b0, 1'b0);
        applyStimulus(8'h29, 1'b0, 3, 11);
        pushExp(8'h5A, 1'b0, 1'b0);
        applyStimulus(8'h5A, 1'b0, 7, 11);
        waitDrain("glitched frames");
        checkOutput("no error from glitches", errPulses - e0, 0);

        // Prefix sequences.
`ifdef PS2_PREFIX_DECODE_EN
        pushExp(8'h29, 1'b1, 1'b0);
        pushExp(8'h75, 1'b0, 1'b1);
`else
        pushExp(8'hF0, 1'b0, 1'b0);
        pushExp(8'h29, 1'b0, 1'b0);
        pushExp(8'hE0, 1'b0, 1'b0);
        pushExp(8'h75, 1'b0, 1'b0);
`endif
        applyStimulus(8'hF0, 1'b0, -1, 11);
        applyStimulus(8'h29, 1'b0, -1, 11);
        applyStimulus(8'hE0, 1'b0, -1, 11);
        applyStimulus(8'h75, 1'b0, -1, 11);
        waitDrain("prefix sequences");

        checkOutput("scoreboard empty", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
